// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: ALU opcode encoding, the LDI
// opcode bit, flag bit positions and a packed instruction record sized for
// the default configuration (BW=16, NREG=8).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OPW     = 4;   // opcode width on the instruction bus
  localparam int FLAGW   = 3;   // {overflow, negative, zero}
  localparam int LDI_BIT = 3;   // opcode 4'b1xxx is load-immediate

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Default geometry; the modules are parameterised but default to these.
  localparam int PKG_BW   = 16;
  localparam int PKG_NREG = 8;
  localparam int PKG_RW   = $clog2(PKG_NREG);

  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    AND_L  = 3'd2,
    OR_L   = 3'd3,
    XOR_L  = 3'd4,
    INC    = 3'd5,
    PASS_A = 3'd6,
    PASS_B = 3'd7
  } alu_op_e;

  localparam logic [OPW-1:0] LDI_OP = 4'b1000;

  typedef struct packed {
    logic [OPW-1:0]    opcode;
    logic [PKG_RW-1:0] dst;
    logic [PKG_RW-1:0] src_a;
    logic [PKG_RW-1:0] src_b;
    logic [PKG_BW-1:0] imm;
  } alu_instr_t;

  // Widen an ALU operation to the 4-bit bus opcode (LDI bit clear).
  function automatic logic [OPW-1:0] alu_opcode(input alu_op_e op);
    return {1'b0, op};
  endfunction

  function automatic logic is_ldi(input logic [OPW-1:0] opcode);
    return opcode[LDI_BIT];
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles the three buses around the issue stage:
//   instruction  : instr_valid/instr_ready handshake + opcode, dst, src_a,
//                  src_b, imm
//   ALU          : alu_a, alu_b, alu_opcode out; alu_out, alu_flags back
//   writeback    : wb_valid, wb_dst, wb_data, architectural flags_q
// modport slave  : the issue stage itself
// modport master : the environment (instruction source, ALU, wb observer)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int BW   = 16,
  parameter int NREG = 8
);
  localparam int RW = $clog2(NREG);

  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_opcode;
  logic [RW-1:0] instr_dst;
  logic [RW-1:0] instr_src_a;
  logic [RW-1:0] instr_src_b;
  logic [BW-1:0] instr_imm;

  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [3:0]    alu_opcode;
  logic [BW-1:0] alu_out;
  logic [2:0]    alu_flags;

  logic          wb_valid;
  logic [RW-1:0] wb_dst;
  logic [BW-1:0] wb_data;
  logic [2:0]    flags_q;

  modport slave (
    input  instr_valid, instr_opcode, instr_dst, instr_src_a, instr_src_b,
           instr_imm, alu_out, alu_flags,
    output instr_ready, alu_a, alu_b, alu_opcode,
           wb_valid, wb_dst, wb_data, flags_q
  );

  modport master (
    output instr_valid, instr_opcode, instr_dst, instr_src_a, instr_src_b,
           instr_imm, alu_out, alu_flags,
    input  instr_ready, alu_a, alu_b, alu_opcode,
           wb_valid, wb_dst, wb_data, flags_q
  );

endinterface

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREG x BW register file: two combinational read ports, one synchronous
// write port, asynchronous active-low reset of every entry to zero.
// Ports:
//   clk, rst_n               clock / async active-low reset
//   raddr_a_i / rdata_a_o    read port A
//   raddr_b_i / rdata_b_o    read port B
//   we_i, waddr_i, wdata_i   write port (takes effect on the rising edge)
// Reads return the pre-write contents during a cycle with a write.
// -----------------------------------------------------------------------------
module alu_regfile #(
  parameter int BW   = 16,
  parameter int NREG = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] raddr_a_i,
  output logic [BW-1:0] rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [BW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [BW-1:0] wdata_i
);

  logic [BW-1:0] rf_q [NREG];

  // NOTE: this storage is reset because architectural registers must read
  // as zero after reset; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = rf_q[raddr_a_i];
  assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Single-issue execute stage in front of an external combinational ALU.
// An instruction accepted on edge N has its operands (read from the internal
// register file) registered onto alu_a/alu_b/alu_opcode for cycle N..N+1;
// on edge N+1 the result (ALU output, or the immediate for LDI) is written
// to the register file and reported on wb_*. ALU ops also update flags_q.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus_if       alu_issue_stage_if.slave: instruction handshake, ALU
//                operand/result bus, writeback and flags outputs
//
// Configuration macro: ALU_ISSUE_FWD_EN
//   defined   - a source matching the in-flight destination is forwarded
//               from the writeback value; instr_ready is 1 out of reset.
//   undefined - such a read-after-write hazard stalls for one cycle and the
//               operand is then read from the updated register file.
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int BW   = 16,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus_if
);

  localparam int RW = $clog2(NREG);

  // Execute (E) stage registers
  logic          e_valid_q, e_valid_d;
  logic          e_ldi_q,   e_ldi_d;
  logic [RW-1:0] e_dst_q,   e_dst_d;
  logic [BW-1:0] e_imm_q,   e_imm_d;
  logic [BW-1:0] alu_a_q,   alu_a_d;
  logic [BW-1:0] alu_b_q,   alu_b_d;
  logic [3:0]    alu_op_q,  alu_op_d;

  // Writeback registers
  logic          wb_valid_q, wb_valid_d;
  logic [RW-1:0] wb_dst_q,   wb_dst_d;
  logic [BW-1:0] wb_data_q,  wb_data_d;
  logic [2:0]    arch_flags_q, arch_flags_d;

  logic          instr_ldi;
  logic          xfer;
  logic          hit_a, hit_b;
  logic [BW-1:0] rd_a, rd_b;
  logic [BW-1:0] opnd_a, opnd_b;
  logic [BW-1:0] wr_data;

  assign instr_ldi = is_ldi(bus_if.instr_opcode);

  // Value written back on the coming edge, also the forwarding source.
  assign wr_data = e_ldi_q ? e_imm_q : bus_if.alu_out;

  assign hit_a = e_valid_q && (bus_if.instr_src_a == e_dst_q);
  assign hit_b = e_valid_q && (bus_if.instr_src_b == e_dst_q);

  alu_regfile #(
    .BW   (BW),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (bus_if.instr_src_a),
    .rdata_a_o (rd_a),
    .raddr_b_i (bus_if.instr_src_b),
    .rdata_b_o (rd_b),
    .we_i      (e_valid_q),
    .waddr_i   (e_dst_q),
    .wdata_i   (wr_data)
  );

`ifdef ALU_ISSUE_FWD_EN
  // The in-flight result bypasses the register file, so nothing ever stalls.
  assign bus_if.instr_ready = rst_n;
  assign opnd_a = hit_a ? wr_data : rd_a;
  assign opnd_b = hit_b ? wr_data : rd_b;
`else
  logic hazard;

  // LDI does not read its sources, so it never waits on them.
  assign hazard = bus_if.instr_valid && !instr_ldi && (hit_a || hit_b);

  // A stall cycle has no transfer, so e_valid drops and the hazard clears
  // after exactly one cycle, by which time the register file holds the value.
  assign bus_if.instr_ready = rst_n && !hazard;
  assign opnd_a = rd_a;
  assign opnd_b = rd_b;
`endif

  assign xfer = bus_if.instr_valid && bus_if.instr_ready;

  // NOTE: every next-state signal gets a hold/default value before any
  // conditional update, so no path through this block can infer a latch.
  always_comb begin
    e_valid_d    = xfer;
    e_ldi_d      = e_ldi_q;
    e_dst_d      = e_dst_q;
    e_imm_d      = e_imm_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    wb_valid_d   = e_valid_q;
    wb_dst_d     = wb_dst_q;
    wb_data_d    = wb_data_q;
    arch_flags_d = arch_flags_q;

    if (xfer) begin
      e_ldi_d  = instr_ldi;
      e_dst_d  = bus_if.instr_dst;
      e_imm_d  = bus_if.instr_imm;
      alu_a_d  = opnd_a;
      alu_b_d  = opnd_b;
      alu_op_d = bus_if.instr_opcode;
    end

    if (e_valid_q) begin
      wb_dst_d  = e_dst_q;
      wb_data_d = wr_data;
      if (!e_ldi_q) arch_flags_d = bus_if.alu_flags;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q    <= 1'b0;
      e_ldi_q      <= 1'b0;
      e_dst_q      <= '0;
      e_imm_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_dst_q     <= '0;
      wb_data_q    <= '0;
      arch_flags_q <= '0;
    end else begin
      e_valid_q    <= e_valid_d;
      e_ldi_q      <= e_ldi_d;
      e_dst_q      <= e_dst_d;
      e_imm_q      <= e_imm_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      wb_valid_q   <= wb_valid_d;
      wb_dst_q     <= wb_dst_d;
      wb_data_q    <= wb_data_d;
      arch_flags_q <= arch_flags_d;
    end
  end

  assign bus_if.alu_a      = alu_a_q;
  assign bus_if.alu_b      = alu_b_q;
  assign bus_if.alu_opcode = alu_op_q;
  assign bus_if.wb_valid   = wb_valid_q;
  assign bus_if.wb_dst     = wb_dst_q;
  assign bus_if.wb_data    = wb_data_q;
  assign bus_if.flags_q    = arch_flags_q;

endmodule
